wvb_rdout_arbiter: RTL and testbench
====================================

Name: wvb_rdout_arbiter

Overview:
- Round-robin scheduler that shares the single waveform-buffer reader between N_CHANNELS waveform buffers.
- Monitors each channel's waveform count and grants one channel at a time to the reader via a req/ack handshake.
- Holds off while the readout DPRAM is busy, then grants the next channel.
- Sits between the per-channel waveform buffers and the wvb reader. Enable, status and error flags map onto the CRS register file.

Parameters:
- N_CHANNELS, 2, number of waveform buffers arbitrated.
- SEL_W, 1, width of channel index; must satisfy 2**SEL_W >= N_CHANNELS.
- N_WVF_W, 10, width of each per-channel waveform count.
- TIMEOUT, 65535, max cycles rdr_req may wait for rdr_ack; 16-bit value.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- enable  in  1  arbiter enable (register-driven level).
- n_wvf_in_buf  in  N_CHANNELS*N_WVF_W  flattened counts; channel k at bits [k*N_WVF_W +: N_WVF_W].
- dpram_busy  in  1  readout DPRAM holds unconsumed data.
- rdr_req  out  1  request to reader to read one waveform from rdr_chan.
- rdr_chan  out  SEL_W  granted channel index.
- rdr_ack  in  1  one-cycle pulse: reader finished the waveform.
- rdout_count  out  16  total completed grants; wraps 0xFFFF -> 0.
- timeout_err  out  1  sticky: a request timed out.
- err_clr  in  1  one-cycle pulse clearing timeout_err.
- arb_busy  out  1  high whenever state != IDLE.

Behaviour:
- Reset values: rdr_req=0, rdr_chan=0, rdout_count=0, timeout_err=0, arb_busy=0.
- Reset internals: state=IDLE, last_chan=N_CHANNELS-1, so channel 0 has first priority. Reset mid-operation aborts immediately, including dropping rdr_req.
- All outputs are registered.

FSM states: IDLE, SCAN, REQ, HOLD.
- IDLE:
  - If enable=1, dpram_busy=0, and any count is nonzero -> SCAN next cycle.
  - Otherwise stay.
- SCAN (one cycle):
  - Search channels last_chan+1, last_chan+2, ... modulo N_CHANNELS; first channel with nonzero count wins.
  - Latch the winner into rdr_chan, clear timeout counter -> REQ.
  - If no channel is nonzero (counts changed) or enable=0 -> IDLE, no request.
- REQ:
  - rdr_req=1; rdr_chan held stable.
  - On rdr_ack=1: rdr_req=0 next cycle, last_chan<=rdr_chan, rdout_count+1 -> HOLD.
  - Otherwise the timeout counter increments. When it reaches TIMEOUT with no ack: rdr_req=0, timeout_err<=1, last_chan<=rdr_chan, no count increment -> HOLD.
  - rdr_ack in the same cycle as expiry: ack wins, no error.
- HOLD:
  - Minimum one cycle; this lets the reader raise dpram_busy.
  - Then remain while dpram_busy=1; -> IDLE when dpram_busy=0.

Latency:
- Conditions true in IDLE at cycle N -> SCAN at N+1 -> rdr_req=1 at N+2.
- rdr_ack at cycle M -> rdr_req=0 at M+1, rdout_count updated at M+1.

Enable and handshake rules:
- enable deasserted during REQ or HOLD does not abort; the transaction completes, then the FSM parks in IDLE.
- rdr_ack outside REQ is ignored; no count change.
- err_clr clears timeout_err next cycle. If err_clr coincides with a new timeout, set wins.

Fairness:
- A channel with a nonzero count is granted at most N_CHANNELS-1 other grants after becoming eligible.
- Any channel that is the sole nonzero channel is granted back-to-back.

Test Plan:
1. Reset, enable=1, counts {ch0=3, ch1=3}, reader acks 5 cycles after each req, dpram_busy=0 -> grants alternate 0,1,0,1,0,1; rdout_count=6; first rdr_req 2 cycles after enable sampled.
2. Counts {ch0=0, ch1=4}, ack after 3 cycles -> four consecutive grants to ch1; rdr_chan never 0.
3. dpram_busy held high for 20 cycles after first ack -> no second rdr_req until 2 cycles after dpram_busy falls; arb_busy high throughout HOLD.
4. TIMEOUT=8, reader never acks -> rdr_req high exactly 8 cycles, then low; timeout_err=1, rdout_count unchanged; next grant goes to the other channel. err_clr pulse clears the flag.
5. enable dropped mid-REQ -> ack still completes, count increments, no further requests. Separately: ack coincident with timeout expiry -> timeout_err stays 0.
6. rst asserted while rdr_req=1 -> rdr_req=0, rdr_chan=0, rdout_count=0 next cycle. After release, first grant goes to ch0. Preload rdout_count to 0xFFFF and complete one grant -> count reads 0.

Source files
------------

// File: rtl/wvb_rdout_arbiter.sv
// wvb_rdout_arbiter: round-robin grant of the shared waveform-buffer reader across channels
module wvb_rdout_arbiter #(
  parameter int N_CHANNELS = 2,
  parameter int SEL_W = 1,
  parameter int N_WVF_W = 10,
  parameter int TIMEOUT = 65535
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          enable,
  input  logic [N_CHANNELS*N_WVF_W-1:0] n_wvf_in_buf,
  input  logic                          dpram_busy,
  output logic                          rdr_req,
  output logic [SEL_W-1:0]              rdr_chan,
  input  logic                          rdr_ack,
  output logic [15:0]                   rdout_count,
  output logic                          timeout_err,
  input  logic                          err_clr,
  output logic                          arb_busy
);
  typedef enum logic [1:0] {IDLE, SCAN, REQ, HOLD} state_t;
  localparam logic [15:0] T_LAST = 16'(TIMEOUT - 1);
  state_t r_state, w_state;
  logic [SEL_W-1:0] r_last, w_last, r_chan, w_chan, w_win;
  logic [15:0] r_tcnt, w_tcnt, r_cnt, w_cnt;
  logic r_req, w_req, r_err, w_err, r_busy, w_found;
  logic [N_CHANNELS-1:0] w_nz;
  for (genvar k = 0; k < N_CHANNELS; k++) begin : g_nz
    assign w_nz[k] = |n_wvf_in_buf[k*N_WVF_W +: N_WVF_W];
  end
  // search starts just after the last served channel so priority rotates
  always_comb begin
    logic [SEL_W-1:0] c;
    c = '0;
    w_found = 1'b0;
    w_win = '0;
    for (int i = 1; i <= N_CHANNELS; i++) begin
      c = SEL_W'((int'(r_last) + i) % N_CHANNELS);
      if (!w_found && w_nz[c]) begin
        w_found = 1'b1;
        w_win = c;
      end
    end
  end
  always_comb begin
    w_state = r_state;
    w_req = r_req;
    w_chan = r_chan;
    w_last = r_last;
    w_tcnt = r_tcnt;
    w_cnt = r_cnt;
    w_err = err_clr ? 1'b0 : r_err;
    unique case (r_state)
      IDLE: w_state = (enable && !dpram_busy && |w_nz) ? SCAN : IDLE;
      SCAN: begin
        w_state = (enable && w_found) ? REQ : IDLE;
        w_req = enable && w_found;
        w_chan = (enable && w_found) ? w_win : r_chan;
        w_tcnt = '0;
      end
      REQ: begin
        if (rdr_ack || r_tcnt == T_LAST) begin
          w_state = HOLD;
          w_req = 1'b0;
          w_last = r_chan;
          w_cnt = rdr_ack ? r_cnt + 16'd1 : r_cnt;
          w_err = rdr_ack ? w_err : 1'b1;
        end else
          w_tcnt = r_tcnt + 16'd1;
      end
      HOLD: w_state = dpram_busy ? HOLD : IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_req <= 1'b0;
      r_chan <= '0;
      r_last <= SEL_W'(N_CHANNELS - 1);
      r_tcnt <= '0;
      r_cnt <= '0;
      r_err <= 1'b0;
      r_busy <= 1'b0;
    end else begin
      r_state <= w_state;
      r_req <= w_req;
      r_chan <= w_chan;
      r_last <= w_last;
      r_tcnt <= w_tcnt;
      r_cnt <= w_cnt;
      r_err <= w_err;
      r_busy <= w_state != IDLE;
    end
  end
  assign rdr_req = r_req;
  assign rdr_chan = r_chan;
  assign rdout_count = r_cnt;
  assign timeout_err = r_err;
  assign arb_busy = r_busy;
endmodule

// File: tb/tb_wvb_rdout_arbiter.sv
// tb_wvb_rdout_arbiter: scoreboard bench acting as the waveform reader for the arbiter
module tb_wvb_rdout_arbiter;
  localparam int NC = 2, SW = 1, NW = 10, TO = 8;
  logic clk = 1'b0, rst = 1'b1, enable = 1'b0, dpram_busy = 1'b0, rdr_ack = 1'b0, err_clr = 1'b0;
  logic [NW-1:0] n0 = '0, n1 = '0;
  logic [NC*NW-1:0] counts;
  logic rdr_req, timeout_err, arb_busy;
  logic [SW-1:0] rdr_chan;
  logic [15:0] rdout_count;
  logic [15:0] exp_cnt = '0;
  logic [SW-1:0] q_exp[$];
  int checks = 0, errors = 0;
  assign counts = {n1, n0};
  always #5 clk = ~clk;
  wvb_rdout_arbiter #(.N_CHANNELS(NC), .SEL_W(SW), .N_WVF_W(NW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .enable(enable), .n_wvf_in_buf(counts), .dpram_busy(dpram_busy),
    .rdr_req(rdr_req), .rdr_chan(rdr_chan), .rdr_ack(rdr_ack), .rdout_count(rdout_count),
    .timeout_err(timeout_err), .err_clr(err_clr), .arb_busy(arb_busy)
  );
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic wait_req(output bit ok);
    int n = 0;
    while (!rdr_req && n < 40) begin
      tick();
      n++;
    end
    ok = rdr_req;
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL wait_req: rdr_req=%0b after %0d cycles, required 1", rdr_req, n);
    end
  endtask
  task automatic serve(input int dly);
    bit ok;
    logic [SW-1:0] e;
    wait_req(ok);
    if (!ok) return;
    e = q_exp.size() != 0 ? q_exp.pop_front() : '0;
    checks++;
    if (rdr_chan !== e) begin
      errors++;
      $display("FAIL grant_chan: rdr_chan=%0d required %0d", rdr_chan, e);
    end
    repeat (dly) tick();
    rdr_ack = 1'b1;
    if (e == 1'b0) begin
      if (n0 != 0) n0--;
    end else if (n1 != 0) n1--;
    tick();
    rdr_ack = 1'b0;
    exp_cnt++;
    checks++;
    if (rdr_req !== 1'b0 || rdout_count !== exp_cnt) begin
      errors++;
      $display("FAIL ack_resp: rdr_req=%0b rdout_count=%0d required 0 and %0d", rdr_req, rdout_count, exp_cnt);
    end
  endtask
  task automatic test_reset;
    rst = 1'b1;
    tick();
    tick();
    checks++;
    if (rdr_req !== 1'b0 || rdr_chan !== '0 || rdout_count !== 16'd0 || timeout_err !== 1'b0 || arb_busy !== 1'b0) begin
      errors++;
      $display("FAIL reset: req=%0b chan=%0d cnt=%0d err=%0b busy=%0b required all 0", rdr_req, rdr_chan, rdout_count, timeout_err, arb_busy);
    end
    rst = 1'b0;
    tick();
  endtask
  task automatic test_alternate;
    n0 = 3;
    n1 = 3;
    for (int i = 0; i < 6; i++) q_exp.push_back(SW'(i % 2));
    enable = 1'b1;
    tick();
    checks++;
    if (rdr_req !== 1'b0 || arb_busy !== 1'b1) begin
      errors++;
      $display("FAIL latency_scan: req=%0b busy=%0b required 0 1", rdr_req, arb_busy);
    end
    tick();
    checks++;
    if (rdr_req !== 1'b1) begin
      errors++;
      $display("FAIL latency_req: req=%0b required 1", rdr_req);
    end
    repeat (6) serve(5);
    repeat (10) tick();
    checks++;
    if (rdr_req !== 1'b0 || arb_busy !== 1'b0 || rdout_count !== 16'd6) begin
      errors++;
      $display("FAIL alt_done: req=%0b busy=%0b cnt=%0d required 0 0 6", rdr_req, arb_busy, rdout_count);
    end
  endtask
  task automatic test_single_channel;
    n0 = 0;
    n1 = 4;
    repeat (4) q_exp.push_back(1'b1);
    repeat (4) serve(3);
    repeat (8) tick();
  endtask
  task automatic test_hold;
    n0 = 1;
    n1 = 1;
    q_exp.push_back(1'b0);
    q_exp.push_back(1'b1);
    serve(2);
    dpram_busy = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      checks++;
      if (rdr_req !== 1'b0 || arb_busy !== 1'b1) begin
        errors++;
        $display("FAIL hold_busy: cycle %0d req=%0b busy=%0b required 0 1", i, rdr_req, arb_busy);
      end
    end
    dpram_busy = 1'b0;
    tick();
    checks++;
    if (rdr_req !== 1'b0) begin
      errors++;
      $display("FAIL hold_release: req=%0b required 0", rdr_req);
    end
    serve(2);
    repeat (8) tick();
  endtask
  task automatic test_timeout;
    bit ok;
    int hi = 0;
    n0 = 1;
    n1 = 1;
    wait_req(ok);
    checks++;
    if (rdr_chan !== 1'b0) begin
      errors++;
      $display("FAIL to_chan: rdr_chan=%0d required 0", rdr_chan);
    end
    while (rdr_req && hi < 20) begin
      hi++;
      tick();
    end
    n0 = 0;
    checks++;
    if (hi != TO || timeout_err !== 1'b1 || rdout_count !== exp_cnt) begin
      errors++;
      $display("FAIL timeout: high=%0d err=%0b cnt=%0d required %0d 1 %0d", hi, timeout_err, rdout_count, TO, exp_cnt);
    end
    q_exp.push_back(1'b1);
    serve(2);
    checks++;
    if (timeout_err !== 1'b1) begin
      errors++;
      $display("FAIL err_sticky: err=%0b required 1", timeout_err);
    end
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    checks++;
    if (timeout_err !== 1'b0) begin
      errors++;
      $display("FAIL err_clr: err=%0b required 0", timeout_err);
    end
    repeat (8) tick();
  endtask
  task automatic test_enable_drop;
    bit ok;
    rdr_ack = 1'b1;
    tick();
    rdr_ack = 1'b0;
    tick();
    checks++;
    if (rdout_count !== exp_cnt) begin
      errors++;
      $display("FAIL stray_ack: cnt=%0d required %0d", rdout_count, exp_cnt);
    end
    n0 = 1;
    n1 = 1;
    wait_req(ok);
    enable = 1'b0;
    tick();
    tick();
    rdr_ack = 1'b1;
    n0 = 0;
    tick();
    rdr_ack = 1'b0;
    exp_cnt++;
    checks++;
    if (rdr_req !== 1'b0 || rdout_count !== exp_cnt) begin
      errors++;
      $display("FAIL en_drop_ack: req=%0b cnt=%0d required 0 %0d", rdr_req, rdout_count, exp_cnt);
    end
    for (int i = 0; i < 10; i++) begin
      tick();
      checks++;
      if (rdr_req !== 1'b0) begin
        errors++;
        $display("FAIL en_drop_park: cycle %0d req=%0b required 0", i, rdr_req);
      end
    end
    checks++;
    if (arb_busy !== 1'b0) begin
      errors++;
      $display("FAIL en_drop_idle: busy=%0b required 0", arb_busy);
    end
    enable = 1'b1;
    q_exp.push_back(1'b1);
    serve(TO - 1);
    tick();
    checks++;
    if (timeout_err !== 1'b0) begin
      errors++;
      $display("FAIL ack_at_expiry: err=%0b required 0", timeout_err);
    end
    repeat (8) tick();
  endtask
  task automatic test_reset_mid;
    bit ok;
    n0 = 0;
    n1 = 1;
    wait_req(ok);
    checks++;
    if (rdr_chan !== 1'b1) begin
      errors++;
      $display("FAIL rst_pre_chan: rdr_chan=%0d required 1", rdr_chan);
    end
    rst = 1'b1;
    tick();
    checks++;
    if (rdr_req !== 1'b0 || rdr_chan !== '0 || rdout_count !== 16'd0 || arb_busy !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid: req=%0b chan=%0d cnt=%0d busy=%0b required 0 0 0 0", rdr_req, rdr_chan, rdout_count, arb_busy);
    end
    exp_cnt = '0;
    n0 = 1;
    n1 = 1;
    rst = 1'b0;
    q_exp.push_back(1'b0);
    q_exp.push_back(1'b1);
    serve(2);
    serve(2);
    repeat (8) tick();
    dut.r_cnt = 16'hFFFF;
    exp_cnt = 16'hFFFF;
    n0 = 1;
    q_exp.push_back(1'b0);
    serve(2);
    checks++;
    if (rdout_count !== 16'd0) begin
      errors++;
      $display("FAIL wrap: cnt=%0d required 0", rdout_count);
    end
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1);
  end
  initial begin
    test_reset();
    test_alternate();
    test_single_channel();
    test_hold();
    test_timeout();
    test_enable_drop();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
